rng_arbiter: RTL and testbench
==============================

# rng_arbiter

Round-robin scheduler that shares one random-number generator (LFSR/NLFSR core with nibble and demux outputs) between NREQ requesters. It configures the generator's mode, reloads its seed when a reseed is pending, waits a warm-up interval, assembles one 8-bit random byte and returns it to the winning requester over a valid/ready handshake. It sits between the RNG core and the consumer blocks.

## Interface
- NREQ, 4, number of requesters (2..8)
- WARMUP, 4, generator clocks discarded before capture (1..15)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester level request; held until its handshake completes
- mode  in  2  generator mode: 00 LFSR nibble, 01 NLFSR nibble, 10 LFSR demux, 11 NLFSR demux; sampled at arbitration
- seed  in  4  seed value used on reload
- reseed  in  1  single-cycle pulse; marks a reload pending
- gen_mode  out  2  mode driven to the generator
- gen_seed  out  4  seed driven to the generator
- gen_load  out  1  one-cycle pulse: generator loads gen_seed
- gen_data  in  8  generator output (nibble modes use [3:0])
- grant  out  NREQ  one-hot owner of the current transaction
- rsp_valid  out  1  random byte available
- rsp_data  out  8  random byte
- rsp_id  out  clog2(NREQ)  index of the owner
- rsp_ready  in  1  consumer accepts rsp_data

## Operation
- States: IDLE, LOAD, WARM, CAP0, CAP1, RESP.
- IDLE: when req is nonzero, pick the first set bit at or after the rr pointer (with wrap), latch the winner and mode, and set grant. If reseed_pending=1, go to LOAD, otherwise go to WARM.
- LOAD: gen_load=1 for one cycle. Clear reseed_pending. Go to WARM.
- WARM: count WARMUP cycles, then go to CAP0.
- CAP0: in nibble modes, capture gen_data[3:0] into byte[7:4] and go to CAP1. In demux modes, capture gen_data[7:0] and go to RESP.
- CAP1: capture gen_data[3:0] into byte[3:0]. Go to RESP.
- RESP: rsp_valid=1. rsp_data and rsp_id are stable. On rsp_valid&&rsp_ready, drop grant, set the rr pointer to winner+1 (mod NREQ) and go to IDLE.
- Abort: if the winner's req drops in any state other than IDLE, go to IDLE next cycle without asserting rsp_valid. The pointer advances. Any pending reseed is preserved unless LOAD already completed.
- Zero seed: a seed of 0 locks up the LFSR, so gen_seed is forced to 4'h1 when seed==4'h0.
- reseed_pending is set by reset and by any reseed pulse. If a pulse arrives in the same cycle as LOAD, set wins: the flag stays 1.
- gen_mode holds the latched mode. A change on mode mid-transaction is ignored.
- Reset (async, any state): state=IDLE, grant=0, rsp_valid=0, rsp_data=0, rsp_id=0, gen_load=0, gen_mode=00, gen_seed=seed-mapped combinationally, rr pointer=0, reseed_pending=1.

## Timing
- All outputs are registered except gen_seed.
- Latency is counted from the IDLE cycle that sees req (cycle t):
  - grant from t+1.
  - Nibble mode, no reload: rsp_valid at t+WARMUP+3.
  - LOAD adds 1 cycle.
  - Demux mode subtracts 1 cycle.
- rsp_valid may stay high indefinitely under backpressure. Data must not change while it is high.
- Next arbitration happens in the IDLE cycle after the handshake. Minimum spacing between responses is WARMUP+4 cycles (nibble, no reload).

## Structure
- Shared package rng_pkg holds:
  - state enum (IDLE, LOAD, WARM, CAP0, CAP1, RESP);
  - mode constants MODE_LFSR_NIB=2'b00, MODE_NLFSR_NIB=2'b01, MODE_LFSR_DMX=2'b10, MODE_NLFSR_DMX=2'b11;
  - SEED_NONZERO=4'h1.
- Sub-module rr_arbiter: combinational round-robin pick from req and pointer, producing a one-hot result and an index.

## Test plan
- Reset release, req=4'b0001, mode=00, seed=4'h9, bench drives gen_data=counter starting at 0 from LOAD -> gen_load pulse at t+1 with gen_seed=9; captures at t+6 (gen_data=5) and t+7 (gen_data=6); rsp_valid at t+8, rsp_data=8'h56, rsp_id=0.
- req=4'b1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0. Only the first transaction has LOAD.
- Mode 10, gen_data=8'hC3 constant, no reload -> rsp_valid at t+6, rsp_data=8'hC3.
- seed=0 with reseed pulse -> gen_seed=4'h1 during LOAD. A reseed pulse in the LOAD cycle -> the next transaction also has LOAD.
- rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_data and rsp_id are stable; handshake on the cycle rsp_ready=1, then IDLE.
- Winner drops req during WARM -> no rsp_valid, grant=0 next cycle, next requester served. reset=0 mid-CAP1 -> all outputs reach reset values immediately.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and constants for the RNG round-robin scheduler.
package rng_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WARM,
        CAP0,
        CAP1,
        RESP
    } state_e;

    localparam logic [1:0] MODE_LFSR_NIB  = 2'b00;
    localparam logic [1:0] MODE_NLFSR_NIB = 2'b01;
    localparam logic [1:0] MODE_LFSR_DMX  = 2'b10;
    localparam logic [1:0] MODE_NLFSR_DMX = 2'b11;

    localparam logic [3:0] SEED_NONZERO = 4'h1;

    // An all-zero seed is a fixed point of the LFSR, so it is never passed through.
    function automatic logic [3:0] seed_map(input logic [3:0] s);
        return (s == 4'h0) ? SEED_NONZERO : s;
    endfunction

    function automatic logic is_demux(input logic [1:0] m);
        logic r;
        case (m)
            MODE_LFSR_DMX, MODE_NLFSR_DMX: r = 1'b1;
            MODE_LFSR_NIB, MODE_NLFSR_NIB: r = 1'b0;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rng_arbiter_if.sv
// Requester, generator and response signals of the RNG scheduler.
interface rng_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [1:0]      mode;
    logic [3:0]      seed;
    logic            reseed;
    logic [1:0]      gen_mode;
    logic [3:0]      gen_seed;
    logic            gen_load;
    logic [7:0]      gen_data;
    logic [NREQ-1:0] grant;
    logic            rsp_valid;
    logic [7:0]      rsp_data;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_ready;

    modport master (
        output req, mode, seed, reseed, gen_data, rsp_ready,
        input  gen_mode, gen_seed, gen_load, grant, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req, mode, seed, reseed, gen_data, rsp_ready,
        output gen_mode, gen_seed, gen_load, grant, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/rng_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after the pointer, with wrap.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        int c;
        // NOTE: every output gets a value before the loop so no path leaves it unassigned (no latch).
        valid = 1'b0;
        gnt   = '0;
        idx   = '0;
        c     = 0;
        for (int i = 0; i < NREQ; i++) begin
            c = int'(ptr) + i;
            if (c >= NREQ) c = c - NREQ;
            if (!valid && req[c]) begin
                valid  = 1'b1;
                idx    = IDW'(c);
                gnt[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// Shares one RNG core among NREQ requesters: arbitrate, optionally reseed, warm up,
// capture one byte and return it over a valid/ready handshake.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WARMUP = 4
) (
    input logic          clk,
    input logic          reset,
    rng_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [1:0]      mode_q, mode_d;
    logic [7:0]      data_q, data_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            gen_load_q, gen_load_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            reseed_q, reseed_d;
    logic            txn_end;

    logic            pick_valid;
    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .gnt   (pick_gnt),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        grant_d     = grant_q;
        mode_d      = mode_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        gen_load_d  = 1'b0;
        rsp_valid_d = 1'b0;
        // A pulse landing in the LOAD cycle must outlive the clear.
        reseed_d    = bus.reseed | (reseed_q & (state_q != LOAD));
        txn_end     = (state_q != IDLE) && !bus.req[id_q];

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_gnt;
                    id_d    = pick_idx;
                    mode_d  = bus.mode;
                    cnt_d   = '0;
                    if (reseed_q) begin
                        state_d    = LOAD;
                        gen_load_d = 1'b1;
                    end else begin
                        state_d = WARM;
                    end
                end
            end
            LOAD: state_d = WARM;
            WARM: begin
                if (cnt_q == 4'(WARMUP - 1)) state_d = CAP0;
                else                         cnt_d   = cnt_q + 4'd1;
            end
            CAP0: begin
                if (is_demux(mode_q)) begin
                    data_d      = bus.gen_data;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    data_d  = {bus.gen_data[3:0], data_q[3:0]};
                    state_d = CAP1;
                end
            end
            CAP1: begin
                data_d      = {data_q[7:4], bus.gen_data[3:0]};
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                if (rsp_valid_q && bus.rsp_ready) txn_end = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Completion and abort both release the owner and move the pointer past it.
        if (txn_end) begin
            state_d     = IDLE;
            grant_d     = '0;
            rsp_valid_d = 1'b0;
            gen_load_d  = 1'b0;
            ptr_d       = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            grant_q     <= '0;
            mode_q      <= MODE_LFSR_NIB;
            data_q      <= '0;
            cnt_q       <= '0;
            gen_load_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            reseed_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            grant_q     <= grant_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            gen_load_q  <= gen_load_d;
            rsp_valid_q <= rsp_valid_d;
            reseed_q    <= reseed_d;
        end
    end

    assign bus.gen_mode  = mode_q;
    assign bus.gen_seed  = seed_map(bus.seed);
    assign bus.gen_load  = gen_load_q;
    assign bus.grant     = grant_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed bench for rng_arbiter: transaction table plus abort, round-robin and reset sequences.
module tb_rng_arbiter;
    import rng_pkg::*;

    localparam int NREQ   = 4;
    localparam int WARMUP = 4;

    typedef struct {
        logic [3:0] req;
        logic [1:0] mode;
        logic [3:0] seed;
        logic       pre_reseed;
        logic       cnt_data;
        logic [7:0] cdata;
        logic       rs_in_load;
        int         hold;
        int         exp_id;
        int         exp_lat;
        logic       exp_load;
        logic [3:0] exp_gseed;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[6];
    vec_t v;
    int   rr_exp[5] = '{0, 1, 2, 3, 0};
    int   rr_id[5];
    int   rr_at[5];
    logic rr_load[5];

    rng_arbiter_if #(.NREQ(NREQ)) bus ();

    rng_arbiter #(.NREQ(NREQ), .WARMUP(WARMUP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        bus.req       = '0;
        bus.rsp_ready = 1'b0;
        bus.reseed    = 1'b0;
        reset         = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Starts in an IDLE cycle at a negedge; that cycle is t.
    task automatic do_txn(input vec_t tv);
        int         lat, load_at, n_load;
        logic [3:0] seed_at_load;
        logic [3:0] onehot;
        logic       got;
        if (tv.pre_reseed) begin
            bus.reseed = 1'b1;
            @(negedge clk);
            bus.reseed = 1'b0;
        end
        bus.req  = tv.req;
        bus.mode = tv.mode;
        bus.seed = tv.seed;
        onehot   = 4'b0001 << tv.exp_id;
        lat = 0; load_at = -1; n_load = 0; seed_at_load = '0; got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            bus.gen_data = tv.cnt_data ? 8'(k - 1) : tv.cdata;
            bus.reseed   = (k == 1) && tv.rs_in_load;
            if (k == 1) begin
                check("grant_t1", bus.grant, onehot);
                bus.mode = ~tv.mode;
            end
            if (bus.gen_load) begin
                n_load++;
                if (load_at < 0) begin
                    load_at      = k;
                    seed_at_load = bus.gen_seed;
                end
            end
            if (bus.rsp_valid) begin
                got = 1'b1;
                lat = k;
            end
        end
        bus.reseed = 1'b0;
        check("rsp_seen", got, 1);
        check("latency", lat, tv.exp_lat);
        check("load_cycles", n_load, tv.exp_load ? 1 : 0);
        if (tv.exp_load) begin
            check("load_at", load_at, 1);
            check("gen_seed", seed_at_load, tv.exp_gseed);
        end
        check("rsp_id", bus.rsp_id, tv.exp_id);
        check("rsp_data", bus.rsp_data, tv.exp_data);
        check("gen_mode", bus.gen_mode, tv.mode);
        check("grant_resp", bus.grant, onehot);
        for (int h = 0; h < tv.hold; h++) begin
            bus.gen_data = bus.gen_data + 8'h35;
            @(negedge clk);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_data", bus.rsp_data, tv.exp_data);
            check("hold_id", bus.rsp_id, tv.exp_id);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req       = '0;
        check("post_valid", bus.rsp_valid, 0);
        check("post_grant", bus.grant, 0);
        @(negedge clk);
    endtask

    initial begin
        logic any_valid;
        int   n_rsp;
        logic load_seen;

        vecs[0] = '{4'b0001, 2'b00, 4'h9, 1'b0, 1'b1, 8'h00, 1'b0, 0,  0, 8, 1'b1, 4'h9, 8'h56};
        vecs[1] = '{4'b0001, 2'b01, 4'h5, 1'b0, 1'b0, 8'hA7, 1'b0, 10, 0, 7, 1'b0, 4'h0, 8'h77};
        vecs[2] = '{4'b1001, 2'b10, 4'h5, 1'b0, 1'b0, 8'hC3, 1'b0, 0,  3, 6, 1'b0, 4'h0, 8'hC3};
        vecs[3] = '{4'b0110, 2'b01, 4'h5, 1'b0, 1'b1, 8'h00, 1'b0, 0,  1, 7, 1'b0, 4'h0, 8'h45};
        vecs[4] = '{4'b0011, 2'b11, 4'h0, 1'b1, 1'b1, 8'h00, 1'b1, 0,  0, 7, 1'b1, 4'h1, 8'h05};
        vecs[5] = '{4'b0100, 2'b00, 4'hB, 1'b0, 1'b0, 8'h3C, 1'b0, 0,  2, 8, 1'b1, 4'hB, 8'hCC};

        reset         = 1'b0;
        bus.req       = '0;
        bus.mode      = 2'b00;
        bus.seed      = 4'h0;
        bus.reseed    = 1'b0;
        bus.gen_data  = 8'h00;
        bus.rsp_ready = 1'b0;
        #1;
        check("rst_grant", bus.grant, 0);
        check("rst_valid", bus.rsp_valid, 0);
        check("rst_data", bus.rsp_data, 0);
        check("rst_id", bus.rsp_id, 0);
        check("rst_load", bus.gen_load, 0);
        check("rst_mode", bus.gen_mode, 0);
        check("rst_seed_map", bus.gen_seed, 4'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Winner drops its request in WARM; the next requester is served without a reload.
        do_reset();
        bus.seed     = 4'h7;
        bus.mode     = 2'b00;
        bus.gen_data = 8'h21;
        bus.req      = 4'b0011;
        any_valid    = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            any_valid = any_valid | bus.rsp_valid;
        end
        check("abort_owner", bus.grant, 4'b0001);
        bus.req = 4'b0010;
        @(negedge clk);
        check("abort_valid", any_valid | bus.rsp_valid, 0);
        check("abort_grant", bus.grant, 0);
        v = '{4'b0010, 2'b00, 4'h7, 1'b0, 1'b0, 8'h21, 1'b0, 0, 1, 7, 1'b0, 4'h0, 8'h11};
        do_txn(v);

        // All requesters held with rsp_ready high: strict rotation, reload only on the first.
        do_reset();
        bus.seed      = 4'h3;
        bus.mode      = 2'b00;
        bus.gen_data  = 8'h11;
        bus.rsp_ready = 1'b1;
        bus.req       = 4'b1111;
        n_rsp         = 0;
        load_seen     = 1'b0;
        for (int k = 1; k <= 120 && n_rsp < 5; k++) begin
            @(negedge clk);
            if (bus.gen_load) load_seen = 1'b1;
            if (bus.rsp_valid) begin
                rr_id[n_rsp]   = int'(bus.rsp_id);
                rr_load[n_rsp] = load_seen;
                rr_at[n_rsp]   = k;
                load_seen      = 1'b0;
                n_rsp++;
                if (n_rsp == 5) bus.req = '0;
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rr_count", n_rsp, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_id%0d", i), rr_id[i], rr_exp[i]);
            check($sformatf("rr_load%0d", i), rr_load[i], (i == 0) ? 1 : 0);
        end
        check("rr_first_lat", rr_at[0], 8);
        check("rr_spacing", rr_at[2] - rr_at[1], WARMUP + 4);

        // Asynchronous reset while in CAP1.
        do_reset();
        bus.seed     = 4'h4;
        bus.mode     = 2'b01;
        bus.gen_data = 8'h9A;
        bus.req      = 4'b0100;
        for (int k = 1; k <= 7; k++) @(negedge clk);
        check("cap1_grant", bus.grant, 4'b0100);
        check("cap1_data", bus.rsp_data, 8'hA0);
        check("cap1_id", bus.rsp_id, 2);
        reset = 1'b0;
        #1;
        check("arst_grant", bus.grant, 0);
        check("arst_valid", bus.rsp_valid, 0);
        check("arst_data", bus.rsp_data, 0);
        check("arst_id", bus.rsp_id, 0);
        check("arst_load", bus.gen_load, 0);
        check("arst_mode", bus.gen_mode, 0);
        @(negedge clk);
        bus.req = '0;
        reset   = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
